// File: rtl/c432_irq_seq.sv
// c432_irq_seq: qualifies the winning request of the 27-channel priority
// encoder, raises one CPU interrupt at a time and reports the serviced
// request upstream once the CPU acknowledges it.
// Optional build macro IRQ_TIMEOUT_EN adds a PEND timeout with a tmo pulse.
module c432_irq_seq #(
  parameter int STABLE_CYC = 2,
  parameter int TMO_CYC    = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pa,
  input  logic       pb,
  input  logic       pc,
  input  logic [3:0] chan,
  input  logic       ack,
  output logic       irq,
  output logic [5:0] irq_id,
  output logic       svc_valid,
  output logic [5:0] svc_id,
  output logic       busy,
  output logic       err
`ifdef IRQ_TIMEOUT_EN
  ,
  output logic       tmo
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] QUAL = 2'd1;
  localparam logic [1:0] PEND = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [3:0] STABLE_L = 4'(STABLE_CYC);

  // Reject parameter values the counters cannot represent.
  if (STABLE_CYC < 1 || STABLE_CYC > 15 || TMO_CYC < 1 || TMO_CYC > 255) begin : g_param_chk
    $error("c432_irq_seq: STABLE_CYC or TMO_CYC out of range");
  end

  logic [1:0] state_q, state_d;
  logic [5:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic       irq_q, irq_d;
  logic [5:0] irq_id_q, irq_id_d;
  logic       svc_valid_q, svc_valid_d;
  logic [5:0] svc_id_q, svc_id_d;
  logic       err_q, err_d;
`ifdef IRQ_TIMEOUT_EN
  localparam logic [7:0] TMO_L = 8'(TMO_CYC);
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       tmo_q, tmo_d;
`endif

  logic [1:0] bus;
  logic       one_hot;
  logic       smp_valid;
  logic       smp_illegal;
  logic [5:0] smp_id;

  // Classify the current bus/channel sample as valid, idle or illegal.
  always_comb begin
    bus         = pa ? 2'b01 : (pb ? 2'b10 : 2'b11);
    one_hot     = (({1'b0, pa} + {1'b0, pb} + {1'b0, pc}) == 2'd1);
    smp_valid   = one_hot && (chan <= 4'd8);
    smp_illegal = (pa | pb | pc) && !smp_valid;
    smp_id      = {bus, chan};
  end

  // Next-state logic: qualify, pend until ack (or timeout), then report service.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    irq_d       = irq_q;
    irq_id_d    = irq_id_q;
    svc_valid_d = 1'b0;
    svc_id_d    = svc_id_q;
    err_d       = err_q;
`ifdef IRQ_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    tmo_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (smp_valid) begin
          cand_d = smp_id;
          cnt_d  = 4'd1;
          if (STABLE_L == 4'd1) begin
            state_d  = PEND;
            irq_d    = 1'b1;
            irq_id_d = smp_id;
            cnt_d    = 4'd0;
          end else begin
            state_d = QUAL;
          end
        end else if (smp_illegal) begin
          err_d = 1'b1;
        end
      end
      QUAL: begin
        if (smp_valid) begin
          if (smp_id == cand_q) begin
            if (cnt_q + 4'd1 == STABLE_L) begin
              state_d  = PEND;
              irq_d    = 1'b1;
              irq_id_d = cand_q;
              cnt_d    = 4'd0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            // A different winner restarts qualification from scratch.
            cand_d = smp_id;
            cnt_d  = 4'd1;
          end
        end else begin
          err_d   = err_q | smp_illegal;
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      PEND: begin
        if (ack) begin
          state_d     = DONE;
          irq_d       = 1'b0;
          svc_valid_d = 1'b1;
          svc_id_d    = irq_id_q;
`ifdef IRQ_TIMEOUT_EN
          tmo_cnt_d   = 8'd0;
        end else if (tmo_cnt_q + 8'd1 == TMO_L) begin
          state_d   = IDLE;
          irq_d     = 1'b0;
          tmo_d     = 1'b1;
          tmo_cnt_d = 8'd0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        // DONE: svc_valid is high for this single cycle; inputs are not sampled.
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cand_q      <= 6'd0;
      cnt_q       <= 4'd0;
      irq_q       <= 1'b0;
      irq_id_q    <= 6'd0;
      svc_valid_q <= 1'b0;
      svc_id_q    <= 6'd0;
      err_q       <= 1'b0;
`ifdef IRQ_TIMEOUT_EN
      tmo_cnt_q   <= 8'd0;
      tmo_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      irq_q       <= irq_d;
      irq_id_q    <= irq_id_d;
      svc_valid_q <= svc_valid_d;
      svc_id_q    <= svc_id_d;
      err_q       <= err_d;
`ifdef IRQ_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign irq       = irq_q;
  assign irq_id    = irq_id_q;
  assign svc_valid = svc_valid_q;
  assign svc_id    = svc_id_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;
`ifdef IRQ_TIMEOUT_EN
  assign tmo       = tmo_q;
`endif

endmodule
